// File: rtl/aes_pkg.sv
// Shared AES-128 constants and helpers: S-box, xtime, Rcon, scan-chain field map, FSM states.
package aes_pkg;

    localparam int unsigned SCAN_W      = 387;
    localparam int unsigned BLK_W       = 128;
    localparam int unsigned CT_PAD_W    = SCAN_W - BLK_W;
    localparam int unsigned PT_MSB      = 386;
    localparam int unsigned PT_LSB      = 259;
    localparam int unsigned KEY_MSB     = 258;
    localparam int unsigned KEY_LSB     = 131;
    localparam int unsigned PT_SEL_BIT  = 2;
    localparam int unsigned KEY_SEL_BIT = 1;
    localparam int unsigned CT_SEL_BIT  = 0;
    localparam int unsigned RND_W       = 4;

    localparam int unsigned  AES_ROUNDS      = 10;
    localparam logic [127:0] AES_DEFAULT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // Entry 0 sits in the top byte, so entry x lives at bit offset (255-x)*8.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] rnd);
        logic [7:0] v;
        v = 8'h00;
        case (rnd)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES-128 round plus on-the-fly expansion of the next round key.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_key,
    input  logic [7:0]   i_rcon,
    input  logic         i_last,
    output logic [127:0] o_state,
    output logic [127:0] o_key
);

    logic [7:0]  w_shift [16];
    logic [7:0]  w_mix   [16];
    logic [31:0] w_k     [4];
    logic [31:0] w_nk    [4];
    logic [31:0] w_tmp;

    // Next round key: RotWord/SubWord/Rcon on the last word, then the xor chain.
    always_comb begin : key_expand
        for (int j = 0; j < 4; j++) begin
            w_k[j] = i_key[127-32*j -: 32];
        end
        w_tmp = {sbox(w_k[3][23:16]), sbox(w_k[3][15:8]),
                 sbox(w_k[3][7:0]),   sbox(w_k[3][31:24])} ^ {i_rcon, 24'h000000};
        w_nk[0] = w_k[0] ^ w_tmp;
        for (int j = 1; j < 4; j++) begin
            w_nk[j] = w_k[j] ^ w_nk[j-1];
        end
        o_key = {w_nk[0], w_nk[1], w_nk[2], w_nk[3]};
    end

    // SubBytes fused with ShiftRows; byte index is row + 4*column.
    always_comb begin : sub_shift
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shift[4*c+r] = sbox(i_state[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
    end

    always_comb begin : mix_columns
        for (int c = 0; c < 4; c++) begin
            w_mix[4*c+0] = xtime(w_shift[4*c+0]) ^ xtime(w_shift[4*c+1]) ^ w_shift[4*c+1]
                         ^ w_shift[4*c+2] ^ w_shift[4*c+3];
            w_mix[4*c+1] = w_shift[4*c+0] ^ xtime(w_shift[4*c+1]) ^ xtime(w_shift[4*c+2])
                         ^ w_shift[4*c+2] ^ w_shift[4*c+3];
            w_mix[4*c+2] = w_shift[4*c+0] ^ w_shift[4*c+1] ^ xtime(w_shift[4*c+2])
                         ^ xtime(w_shift[4*c+3]) ^ w_shift[4*c+3];
            w_mix[4*c+3] = xtime(w_shift[4*c+0]) ^ w_shift[4*c+0] ^ w_shift[4*c+1]
                         ^ w_shift[4*c+2] ^ xtime(w_shift[4*c+3]);
        end
    end

    // AddRoundKey with the freshly expanded key; the final round skips MixColumns.
    always_comb begin : add_key
        o_state = '0;
        for (int i = 0; i < 16; i++) begin
            o_state[127-8*i -: 8] = (i_last ? w_shift[i] : w_mix[i])
                                  ^ w_nk[i/4][31-8*(i%4) -: 8];
        end
    end

endmodule

// File: rtl/aes_if.sv
// Scan-chain-loaded iterative AES-128 encryptor with start/done trigger pulses.
module aes_if
    import aes_pkg::*;
#(
    parameter int unsigned  ROUNDS      = AES_ROUNDS,
    parameter logic [127:0] DEFAULT_KEY = AES_DEFAULT_KEY
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [SCAN_W-1:0] SCAN_CHAIN,
    input  logic              ENABLE,
    output logic              TRIGGER_EXT,
    output logic [SCAN_W-1:0] CIPHERTEXT,
    output logic [BLK_W-1:0]  CT_OUT
);

    fsm_state_t       r_fsm;
    logic [RND_W-1:0] r_round;
    logic [127:0]     r_state;
    logic [127:0]     r_key;
    logic [127:0]     r_fb;
    logic [127:0]     r_ct;
    logic [127:0]     r_ct_out;
    logic             r_ct_sel;
    logic             r_trig;

    logic [127:0]     w_pt;
    logic [127:0]     w_k;
    logic [127:0]     w_rnd_state;
    logic [127:0]     w_rnd_key;
    logic             w_last;
    logic             w_unused_key_lo;

    // Lower half of the key field is reserved and deliberately dropped.
    assign w_unused_key_lo = ^SCAN_CHAIN[KEY_LSB-1:CT_SEL_BIT+3];

    assign w_pt   = SCAN_CHAIN[PT_SEL_BIT]  ? SCAN_CHAIN[PT_MSB:PT_LSB]   : r_fb;
    assign w_k    = SCAN_CHAIN[KEY_SEL_BIT] ? SCAN_CHAIN[KEY_MSB:KEY_LSB] : DEFAULT_KEY;
    assign w_last = (r_round == RND_W'(ROUNDS));

    aes_round u_round (
        .i_state (r_state),
        .i_key   (r_key),
        .i_rcon  (rcon(r_round)),
        .i_last  (w_last),
        .o_state (w_rnd_state),
        .o_key   (w_rnd_key)
    );

    // Control FSM and datapath registers; one round per RUN cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_fsm    <= ST_IDLE;
            r_round  <= '0;
            r_state  <= '0;
            r_key    <= '0;
            r_fb     <= '0;
            r_ct     <= '0;
            r_ct_out <= '0;
            r_ct_sel <= 1'b0;
            r_trig   <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            case (r_fsm)
                ST_IDLE: begin
                    if (ENABLE) begin
                        r_state  <= w_pt ^ w_k;
                        r_key    <= w_k;
                        r_round  <= RND_W'(1);
                        r_ct_sel <= SCAN_CHAIN[CT_SEL_BIT];
                        r_trig   <= 1'b1;
                        r_fsm    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_state <= w_rnd_state;
                    r_key   <= w_rnd_key;
                    r_round <= r_round + RND_W'(1);
                    if (w_last) begin
                        r_ct   <= w_rnd_state;
                        r_fb   <= w_rnd_state;
                        r_trig <= 1'b1;
                        r_fsm  <= ST_DONE;
                        if (r_ct_sel) begin
                            r_ct_out <= w_rnd_state;
                        end
                    end
                end
                ST_DONE: begin
                    r_fsm <= ST_IDLE;
                end
                default: begin
                    r_fsm <= ST_IDLE;
                end
            endcase
        end
    end

    assign TRIGGER_EXT = r_trig;
    assign CIPHERTEXT  = {{CT_PAD_W{1'b0}}, r_ct};
    assign CT_OUT      = r_ct_out;

endmodule

// File: tb/tb_aes_if.sv
// Directed scoreboard bench for aes_if with an independent AES-128 reference model.
module tb_aes_if;

    localparam logic [127:0] DEF_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_FIPS  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_APPB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_APPB = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [386:0] SCAN_CHAIN;
    logic         ENABLE;
    logic         TRIGGER_EXT;
    logic [386:0] CIPHERTEXT;
    logic [127:0] CT_OUT;

    int n_total = 0;
    int n_pass  = 0;
    logic [127:0] exp_q [$];
    logic [127:0] fb;
    logic [7:0]   m_sbox [256];

    aes_if dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .SCAN_CHAIN  (SCAN_CHAIN),
        .ENABLE      (ENABLE),
        .TRIGGER_EXT (TRIGGER_EXT),
        .CIPHERTEXT  (CIPHERTEXT),
        .CT_OUT      (CT_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [386:0] obs, input logic [386:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = m_xt(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse and the affine map, independent of any table.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (m_gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            m_sbox[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]], m_sbox[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc = m_xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = m_sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c+0] = m_gm(t[4*c+0], 8'h02) ^ m_gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c+0] ^ m_gm(t[4*c+1], 8'h02) ^ m_gm(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c+0] ^ t[4*c+1] ^ m_gm(t[4*c+2], 8'h02) ^ m_gm(t[4*c+3], 8'h03);
                    s[4*c+3] = m_gm(t[4*c+0], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ m_gm(t[4*c+3], 8'h02);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic pop_and_check(input string tag, input logic [127:0] exp_out);
        logic [127:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 387'(exp_q.size()), 387'(1));
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_ct"}, CIPHERTEXT, {259'd0, e});
            chk({tag, "_ctout"}, 387'(CT_OUT), 387'(exp_out));
        end
    endtask

    // Single encryption from IDLE: start pulse, done 10 cycles later, scoreboard check.
    task automatic run_enc(input string tag, input logic [127:0] pt, input logic [255:0] kf,
                           input logic ps, input logic ks, input logic cs,
                           input logic [127:0] exp_ct, input logic [127:0] exp_out);
        int t0, t1;
        SCAN_CHAIN = {pt, kf, ps, ks, cs};
        ENABLE = 1'b1;
        exp_q.push_back(exp_ct);
        t0 = -1;
        for (int i = 0; i < 5 && t0 < 0; i++) begin
            @(negedge CLK);
            if (TRIGGER_EXT) t0 = i;
        end
        chk({tag, "_start"}, 387'(t0), 387'(0));
        ENABLE = 1'b0;
        SCAN_CHAIN = ~SCAN_CHAIN;
        t1 = -1;
        for (int i = 1; i <= 30 && t1 < 0; i++) begin
            @(negedge CLK);
            if (TRIGGER_EXT) t1 = i;
        end
        chk({tag, "_latency"}, 387'(t1), 387'(10));
        pop_and_check(tag, exp_out);
        fb = exp_ct;
        @(negedge CLK);
        chk({tag, "_trig_low"}, 387'(TRIGGER_EXT), 387'(0));
    endtask

    initial begin
        logic [127:0] chain_exp, e;
        logic         prev_t;
        int           last_start, last_done, n_start, n_done, n_rise;

        build_sbox();
        RST_N = 1'b0;
        ENABLE = 1'b0;
        SCAN_CHAIN = '0;
        fb = '0;
        repeat (2) @(negedge CLK);
        chk("rst_trig", 387'(TRIGGER_EXT), 387'(0));
        chk("rst_ct", CIPHERTEXT, 387'(0));
        chk("rst_ctout", 387'(CT_OUT), 387'(0));
        RST_N = 1'b1;
        @(negedge CLK);

        run_enc("zero", 128'h0, 256'h0, 1'b1, 1'b1, 1'b0, CT_ZERO, 128'h0);
        chain_exp = aes_model(CT_ZERO, 128'h0);
        run_enc("chain", PT_FIPS, 256'h0, 1'b0, 1'b1, 1'b0, chain_exp, 128'h0);
        run_enc("appb", PT_APPB, {K_FIPS, {128{1'b1}}}, 1'b1, 1'b0, 1'b0, CT_APPB, 128'h0);
        run_enc("fips", PT_FIPS, {K_FIPS, {128{1'b1}}}, 1'b1, 1'b1, 1'b1, CT_FIPS, CT_FIPS);

        // ENABLE held: chained encryptions under the default key, period 12.
        SCAN_CHAIN = {128'h0, 256'h0, 1'b0, 1'b0, 1'b1};
        ENABLE = 1'b1;
        prev_t = 1'b0;
        last_start = -100; last_done = -100; n_start = 0; n_done = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge CLK);
            if (TRIGGER_EXT && !prev_t) begin
                if (n_start == n_done) begin
                    if (n_start > 0) begin
                        chk("b2b_gap", 387'(c - last_done), 387'(2));
                        chk("b2b_period", 387'(c - last_start), 387'(12));
                    end
                    e = aes_model(fb, DEF_KEY);
                    exp_q.push_back(e);
                    fb = e;
                    last_start = c;
                    n_start++;
                end else begin
                    chk("b2b_latency", 387'(c - last_start), 387'(10));
                    pop_and_check("b2b", fb);
                    last_done = c;
                    n_done++;
                end
            end
            prev_t = TRIGGER_EXT;
            if (c == 40) ENABLE = 1'b0;
        end
        chk("b2b_starts", 387'(n_start), 387'(4));
        chk("b2b_dones", 387'(n_done), 387'(4));

        // Reset in the middle of a run aborts it without a done pulse.
        SCAN_CHAIN = {PT_FIPS, K_FIPS, 128'h0, 1'b1, 1'b1, 1'b1};
        ENABLE = 1'b1;
        n_rise = 0;
        for (int i = 0; i < 5 && n_rise == 0; i++) begin
            @(negedge CLK);
            if (TRIGGER_EXT) n_rise = 1;
        end
        chk("abort_start", 387'(n_rise), 387'(1));
        ENABLE = 1'b0;
        repeat (4) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("abort_trig", 387'(TRIGGER_EXT), 387'(0));
        chk("abort_ct", CIPHERTEXT, 387'(0));
        chk("abort_ctout", 387'(CT_OUT), 387'(0));
        n_rise = 0;
        repeat (15) begin
            @(negedge CLK);
            if (TRIGGER_EXT) n_rise++;
        end
        chk("abort_no_done", 387'(n_rise), 387'(0));
        fb = '0;
        run_enc("post_rst", PT_APPB, 256'h0, 1'b0, 1'b1, 1'b1, CT_ZERO, CT_ZERO);
        run_enc("post_rst_fips", PT_FIPS, {K_FIPS, 128'h0}, 1'b1, 1'b1, 1'b0, CT_FIPS, CT_ZERO);

        chk("sb_drained", 387'(exp_q.size()), 387'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
